// File: rtl/ysyx_23060171_sram.sv
// Single-port word memory responding to a valid/ready load/store request with a
// fixed access latency and one registered response per request.
module ysyx_23060171_sram #(
   parameter int unsigned DEPTH = 1024,
   parameter logic [31:0] BASE  = 32'h8000_0000,
   parameter int unsigned LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int unsigned IW       = $clog2(DEPTH);
   localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
   localparam logic [7:0]  CNT_INIT = (LAT == 0) ? 8'd0 : 8'(LAT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic [31:0]   mem [DEPTH];
   logic [IW-1:0] idx_q;
   logic          rd_q;
   logic          err_q;

   logic [31:0]   off;
   logic [IW-1:0] idx;
   logic          in_range;
   logic          accept;
   logic          unused_bits;

   // Wrapping subtraction makes addresses below BASE land far above SPAN.
   assign off         = req_addr - BASE;
   assign idx         = off[IW+1:2];
   assign in_range    = off < SPAN;
   assign req_ready   = (state == IDLE) && !rst;
   assign accept      = req_valid && req_ready;
   assign unused_bits = ^{off[1:0], req_wmask[7:4]};

   // Writes commit on the accept edge, so a later reset cannot undo them.
   always_ff @(posedge clk) begin
      if (accept && req_wen && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (req_wmask[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         idx_q     <= '0;
         rd_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  idx_q <= idx;
                  rd_q  <= !req_wen && in_range;
                  err_q <= !in_range;
                  if (LAT == 0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= (!req_wen && in_range) ? mem[idx] : 32'd0;
                     rsp_err   <= !in_range;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt == 8'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_q ? mem[idx_q] : 32'd0;
                  rsp_err   <= err_q;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_23060171_sram.sv
// Bench for ysyx_23060171_sram: a LAT=2 and a LAT=0 instance driven with directed
// and random transactions, compared against a word-array reference model.
module tb_ysyx_23060171_sram;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

   logic        clk, rst;
   logic [1:0]  req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic [7:0]  req_wmask [2];
   logic [31:0] rsp_rdata [2];

   logic [31:0] ref_mem [2][DEPTH];
   bit          known [2][DEPTH];
   int          n_chk, n_pass;

   ysyx_23060171_sram #(.DEPTH(DEPTH), .BASE(BASE), .LAT(2)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   ysyx_23060171_sram #(.DEPTH(DEPTH), .BASE(BASE), .LAT(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // One full request/response; hold = cycles rsp_ready stays low once valid.
   task automatic xact(input int d, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] wmask,
                       input int hold, input bit extra, output logic [31:0] got);
      logic [31:0] off, exp_d, held;
      bit          inr, check_d;
      int          idx, c;
      off = addr - BASE;
      inr = off < SPAN;
      idx = inr ? int'(off >> 2) : 0;
      if (wen && inr) begin
         for (int b = 0; b < 4; b++)
            if (wmask[b]) ref_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
         if (wmask[3:0] == 4'hF) known[d][idx] = 1'b1;
      end
      exp_d   = (!wen && inr) ? ref_mem[d][idx] : 32'd0;
      check_d = wen || !inr || known[d][idx];
      got     = 32'd0;

      @(negedge clk);
      req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
      req_wdata[d] = wdata; req_wmask[d] = wmask;
      c = 0;
      while (!req_ready[d] && c < 50) begin @(negedge clk); c++; end
      if (!req_ready[d]) begin
         chk("req_timeout", 32'd0, 32'd1);
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (extra) req_addr[d] = addr ^ 32'h40;
      else req_valid[d] = 1'b0;
      if (hold == 0) rsp_ready[d] = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!rsp_valid[d] && c < 300);
      if (!rsp_valid[d]) begin
         chk("rsp_timeout", 32'd0, 32'd1);
         rsp_ready[d] = 1'b0; req_valid[d] = 1'b0;
         return;
      end
      chk("latency", 32'(c), 32'(lat_of(d) + 1));
      chk("rsp_req_ready", 32'(req_ready[d]), 32'd0);
      chk("rsp_err", 32'(rsp_err[d]), 32'(!inr));
      if (check_d) chk("rsp_rdata", rsp_rdata[d], exp_d);
      got  = rsp_rdata[d];
      held = rsp_rdata[d];
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
         chk("hold_rdata", rsp_rdata[d], held);
         chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[d] = 1'b0;
      req_valid[d] = 1'b0;
      @(negedge clk);
      chk("post_req_ready", 32'(req_ready[d]), 32'd1);
      chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
   endtask

   // Accept on the LAT=2 instance, reset one cycle later; no response may appear.
   task automatic abort_xact(input bit wen, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] off;
      bit          seen;
      off = addr - BASE;
      if (wen && off < SPAN) begin
         ref_mem[0][int'(off >> 2)] = wdata;
         known[0][int'(off >> 2)]   = 1'b1;
      end
      @(negedge clk);
      req_valid[0] = 1'b1; req_wen[0] = wen; req_addr[0] = addr;
      req_wdata[0] = wdata; req_wmask[0] = 8'h0F;
      chk("abort_accept_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); seen |= rsp_valid[0]; end
      chk("abort_no_valid", 32'(seen), 32'd0);
      chk("abort_ready", 32'(req_ready[0]), 32'd1);
   endtask

   initial begin
      logic [31:0] got, a;
      bit          w;
      int          d;
      n_chk = 0; n_pass = 0;
      clk = 1'b0; rst = 1'b0;
      req_valid = '0; req_wen = '0; rsp_ready = '0;
      for (int i = 0; i < 2; i++) begin
         req_addr[i] = '0; req_wdata[i] = '0; req_wmask[i] = '0;
      end
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_valid", 32'(rsp_valid[i]), 32'd0);
         chk("reset_rdata", rsp_rdata[i], 32'd0);
         chk("reset_err", 32'(rsp_err[i]), 32'd0);
         chk("reset_ready", 32'(req_ready[i]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("release_ready0", 32'(req_ready[0]), 32'd1);
      chk("release_ready1", 32'(req_ready[1]), 32'd1);

      xact(0, 1'b1, 32'h8000_0010, 32'hDEADBEEF, 8'h0F, 0, 1'b0, got);
      xact(0, 1'b0, 32'h8000_0010, 32'd0, 8'h00, 0, 1'b0, got);
      chk("wr_rd_deadbeef", got, 32'hDEADBEEF);

      xact(0, 1'b1, 32'h8000_0020, 32'h11223344, 8'h0F, 0, 1'b0, got);
      xact(0, 1'b1, 32'h8000_0020, 32'hAABBCCDD, 8'h05, 1, 1'b0, got);
      xact(0, 1'b0, 32'h8000_0022, 32'd0, 8'h00, 0, 1'b0, got);
      chk("byte_mask", got, 32'h11BB33DD);
      xact(0, 1'b1, 32'h8000_0020, 32'hFFFFFFFF, 8'hF0, 0, 1'b0, got);
      xact(0, 1'b0, 32'h8000_0020, 32'd0, 8'h00, 0, 1'b0, got);
      chk("mask_zero", got, 32'h11BB33DD);

      xact(0, 1'b1, 32'h8000_0000, 32'h12345678, 8'h0F, 0, 1'b0, got);
      xact(0, 1'b0, 32'h7FFF_FFFC, 32'd0, 8'h00, 0, 1'b0, got);
      chk("oor_low_rdata", got, 32'd0);
      xact(0, 1'b1, 32'h8000_1000, 32'hFFFFFFFF, 8'h0F, 0, 1'b0, got);
      xact(0, 1'b0, 32'h8000_0000, 32'd0, 8'h00, 0, 1'b0, got);
      chk("oor_no_write", got, 32'h12345678);

      xact(0, 1'b0, 32'h8000_0010, 32'd0, 8'h00, 5, 1'b1, got);
      xact(1, 1'b1, 32'h8000_0100, 32'hCAFEF00D, 8'h0F, 0, 1'b0, got);
      xact(1, 1'b0, 32'h8000_0100, 32'd0, 8'h00, 5, 1'b1, got);
      chk("lat0_read", got, 32'hCAFEF00D);
      xact(1, 1'b0, 32'h8000_1004, 32'd0, 8'h00, 0, 1'b0, got);

      // Async reset while a response is being held.
      @(negedge clk);
      req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0010;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_reset_valid", 32'(rsp_valid[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", 32'(rsp_valid[0]), 32'd0);
      chk("async_rdata", rsp_rdata[0], 32'd0);
      chk("async_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      chk("held_reset_ready", 32'(req_ready[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("after_release_ready", 32'(req_ready[0]), 32'd1);

      abort_xact(1'b0, 32'h8000_0010, 32'd0);
      xact(0, 1'b0, 32'h8000_0010, 32'd0, 8'h00, 0, 1'b0, got);
      abort_xact(1'b1, 32'h8000_0040, 32'h5A5A5A5A);
      xact(0, 1'b0, 32'h8000_0040, 32'd0, 8'h00, 0, 1'b0, got);
      chk("abort_write_kept", got, 32'h5A5A5A5A);

      for (int n = 0; n < 80; n++) begin
         d = int'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = $urandom;
         else a = BASE + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
         xact(d, w, a, $urandom, 8'($urandom), int'($urandom_range(0, 3)),
              !w && ($urandom_range(0, 3) == 0), got);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ysyx_23060171_sram.md
# ysyx_23060171_sram

Single-port word memory that acts as the responder for the core's load/store request interface. The LSU (or IFU) issues one request at a time with a valid/ready handshake. The block applies a configurable access latency and returns one response per request over a second valid/ready handshake. Bus master tests use it as a stand-in for external memory, and it sits on the memory side of the LSU.

## Interface
- `DEPTH`, default 1024: number of 32-bit words; must be a power of two.
- `BASE`, default 32'h8000_0000: byte address of word 0.
- `LAT`, default 2: number of BUSY cycles between request accept and response (legal range 0..255).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address; bits [1:0] ignored.
- `req_wdata`  in  32  write data.
- `req_wmask`  in  8  byte-lane enables; bits [3:0] map to data bytes 3..0; bits [7:4] ignored.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester accepts the response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  address outside [BASE, BASE+4*DEPTH).

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_wen`, `req_addr`, `req_wdata` and `req_wmask`.
  - Compute index = (`req_addr`-BASE)>>2 and range flag.
  - If LAT=0, go to RESP; otherwise go to BUSY with cnt=LAT-1.
- Write commit: on the accept edge, if write and in range, update each byte lane with its mask bit set; all other bytes are unchanged.
  - Mask 0 in range: no change, response still returned with `rsp_err`=0.
- BUSY:
  - `req_ready`=0, `rsp_valid`=0.
  - Each edge: if cnt==0, go to RESP; else cnt-=1.
  - cnt is 8 bits.
- Read sample: on the edge entering RESP, `rsp_rdata` is loaded with array[index] if read and in range, else 0.
  - The value is registered and held stable for the whole RESP state.
- RESP:
  - `rsp_valid`=1, `req_ready`=0.
  - `rsp_rdata` and `rsp_err` are stable until the handshake.
  - On `rsp_valid`&&`rsp_ready`, go to IDLE.
- Out-of-range request: no array write; `rsp_err`=1, `rsp_rdata`=0.
- Range check uses the full 32-bit address. The subtraction wraps, so an address below BASE is out of range.
- Single outstanding request. `req_valid` during BUSY/RESP is ignored and not queued; the requester holds it.
- Storage contents are not cleared by reset.

## Timing
- Reset (async assert):
  - state=IDLE, cnt=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `req_ready` is forced 0 while `rst`=1, and is 1 from the first cycle after deassertion.
- Accept in cycle 0 gives `rsp_valid`=1 first in cycle LAT+1.
- Response handshake in cycle k gives `req_ready`=1 in cycle k+1. There is no same-cycle re-accept.
- Minimum request-to-request period is LAT+2 cycles.
- A read following a write to the same word returns the updated data.
- Reset mid-transaction aborts it: no response is issued, and a write already committed on the accept edge stays.
- `rsp_ready` held low keeps RESP indefinitely with outputs unchanged.
- `rsp_ready` high before `rsp_valid` has no effect.

## Test plan
- Reset then idle:
  - Stimulus: `rst` pulse mid-cycle.
  - Required: outputs go to reset values immediately (async); `req_ready`=1 the cycle after release.
- Write/read, LAT=2:
  - Stimulus: write 0x8000_0010 data 0xDEADBEEF mask 0x0F, then read the same address with `rsp_ready`=1.
  - Required: each `rsp_valid` in cycle 3 after its accept; read `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Byte mask:
  - Stimulus: write 0x11223344 mask 0x0F, then 0xAABBCCDD mask 0x05, then read.
  - Required: read returns 0x11BB33DD.
- Out of range:
  - Stimulus: read 0x7FFF_FFFC, then write 0x8000_1000 (DEPTH=1024).
  - Required: `rsp_err`=1 and `rsp_rdata`=0 on both responses; a subsequent read of 0x8000_0000 is unchanged.
- Backpressure and LAT=0:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles.
  - Required: `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, extra `req_valid` ignored; LAT=0 build gives the response in cycle 1.
- Reset during BUSY:
  - Stimulus: assert `rst` one cycle after accepting a read.
  - Required: `rsp_valid` never asserts for it; the next request completes normally.
